// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizes for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    localparam int DATA_W_DEF    = 8;
    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = NUM_REQ_DEF
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 valid_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic [N-1:0]         onehot_o
);

    localparam int PW = $clog2(N);

    // One extra bit so ptr + offset never overflows before the modulo fold.
    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // Walk offsets from the far end back to 0 so the candidate nearest ptr wins.
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        sum      = '0;
        cand     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (PW + 1)'(k);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            cand = sum[PW-1:0];
            if (req_i[cand]) begin
                valid_o  = 1'b1;
                idx_o    = cand;
                onehot_o = N'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing the FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_W-1:0]           fifo_d_in,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t   state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [BW-1:0] burst_q, burst_d;

    logic          busy_c;
    logic          xfer;
    logic          burst_done;
    logic          release_c;
    logic [IW-1:0] owner_inc;
    logic [IW-1:0] pick_ptr;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    assign busy_c     = (state_q == ARB_GRANT);
    assign owner_inc  = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
    assign xfer       = busy_c & req[owner_q] & ~fifo_full;
    assign burst_done = (burst_q == BW'(MAX_BURST - 1));
    assign release_c  = busy_c & ((xfer & burst_done) | ~req[owner_q]);

    // Idle searches from the saved pointer; a releasing grant searches from
    // the slot after the owner, which is also where ptr lands on release.
    assign pick_ptr = busy_c ? owner_inc : ptr_q;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (pick_ptr),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign busy      = busy_c;
    assign fifo_wr   = xfer;
    assign fifo_d_in = busy_c ? req_data[owner_q*DATA_W +: DATA_W] : '0;

    // Next-state: grant, count, release and same-edge regrant.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        burst_d = burst_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_GRANT;
                    owner_d = pick_idx;
                    gnt_d   = pick_onehot;
                    burst_d = '0;
                end
            end
            ARB_GRANT: begin
                if (release_c) begin
                    ptr_d   = owner_inc;
                    burst_d = '0;
                    if (pick_valid) begin
                        owner_d = pick_idx;
                        gnt_d   = pick_onehot;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end else if (xfer) begin
                    burst_d = burst_q + BW'(1);
                end
            end
        endcase
    end

    // State registers with immediate asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for the FIFO write arbiter
module tb_fifo_wr_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_d_in;
    logic [1:0]  owner;
    logic        busy;

    int   total;
    int   bad;
    int   cyc;
    int   wr_cnt;
    int   first_wr;
    int   last_wr;
    int   rem  [4];
    logic [7:0] base [4];
    logic [7:0] sent [4];
    exp_t sb[$];

    logic [3:0] snap_gnt;
    logic       snap_wr;
    logic [1:0] snap_owner;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_d_in (fifo_d_in),
        .owner     (owner),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i] = (rem[i] != 0);
            req_data[i*8 +: 8] = base[i] + sent[i];
        end
    endtask

    task automatic load(input int i, input int n, input logic [7:0] b);
        base[i] = b;
        sent[i] = '0;
        rem[i]  = n;
    endtask

    task automatic push_burst(input int i, input logic [7:0] b, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.gnt  = 4'(1 << i);
            e.data = b + 8'(k);
            sb.push_back(e);
        end
    endtask

    // One clock: sample at negedge, score writes, advance producers after the edge.
    task automatic step();
        exp_t e;
        int   adv;
        logic xf;
        adv = -1;
        @(negedge clk);
        cyc++;
        snap_gnt   = gnt;
        snap_wr    = fifo_wr;
        snap_owner = owner;
        xf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (gnt[i] && req[i] && !fifo_full) begin
                xf  = 1'b1;
                adv = i;
            end
        end
        if (fifo_wr !== xf) check("wr_strobe", 32'(fifo_wr), 32'(xf));
        if (fifo_wr === 1'b1) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (sb.size() == 0) begin
                check("wr_with_empty_sb", 32'(fifo_wr), 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_data", 32'(fifo_d_in), 32'(e.data));
                check("wr_gnt", 32'(gnt), 32'(e.gnt));
            end
        end
        @(posedge clk);
        #1;
        if (adv >= 0) begin
            sent[adv] = sent[adv] + 8'd1;
            rem[adv]  = rem[adv] - 1;
        end
        drive();
    endtask

    function automatic bit any_rem();
        return (rem[0] != 0) || (rem[1] != 0) || (rem[2] != 0) || (rem[3] != 0);
    endfunction

    task automatic run_done(input int bound);
        int n;
        n = 0;
        while ((sb.size() != 0 || any_rem()) && n < bound) begin
            step();
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic new_test();
        wr_cnt   = 0;
        first_wr = -1;
        last_wr  = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) load(i, 0, 8'h00);
        sb.delete();
        drive();
        step();
        step();
        rst = 1'b0;
        new_test();
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        fifo_full = 1'b0;
        req = '0;
        req_data = '0;
        new_test();

        // Reset held with all four requesting, one word each.
        load(0, 1, 8'h10);
        load(1, 1, 8'h20);
        load(2, 1, 8'h30);
        load(3, 1, 8'h40);
        push_burst(0, 8'h10, 1);
        push_burst(1, 8'h20, 1);
        push_burst(2, 8'h30, 1);
        push_burst(3, 8'h40, 1);
        drive();
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_gnt", 32'(snap_gnt), 32'd0);
            check("rst_wr", 32'(snap_wr), 32'd0);
        end
        rst = 1'b0;
        step();
        step();
        check("first_gnt", 32'(snap_gnt), 32'h1);
        check("first_owner", 32'(snap_owner), 32'd0);
        check("first_wr", 32'(snap_wr), 32'd1);
        run_done(100);
        check("t1_wr_cnt", 32'(wr_cnt), 32'd4);

        // Sole requester keeps the port across burst boundaries.
        do_reset();
        load(1, 8, 8'h11);
        push_burst(1, 8'h11, 8);
        drive();
        run_done(100);
        check("t2_wr_cnt", 32'(wr_cnt), 32'd8);
        check("t2_span", 32'(last_wr - first_wr + 1), 32'd8);
        for (int k = 0; k < 4; k++) begin
            step();
            check("idle_no_wr", 32'(snap_wr), 32'd0);
        end

        // Four requesters rotate in 4-word bursts.
        do_reset();
        load(0, 8, 8'hA0);
        load(1, 8, 8'hB0);
        load(2, 8, 8'hC0);
        load(3, 8, 8'hD0);
        push_burst(0, 8'hA0, 4);
        push_burst(1, 8'hB0, 4);
        push_burst(2, 8'hC0, 4);
        push_burst(3, 8'hD0, 4);
        push_burst(0, 8'hA4, 4);
        push_burst(1, 8'hB4, 4);
        push_burst(2, 8'hC4, 4);
        push_burst(3, 8'hD4, 4);
        drive();
        run_done(200);
        check("t3_wr_cnt", 32'(wr_cnt), 32'd32);
        check("t3_span", 32'(last_wr - first_wr + 1), 32'd32);

        // Full stalls owner 2 mid-burst without consuming burst budget.
        do_reset();
        load(2, 4, 8'h40);
        load(3, 1, 8'h50);
        push_burst(2, 8'h40, 4);
        push_burst(3, 8'h50, 1);
        drive();
        n = 0;
        while (sent[2] != 8'd2 && n < 50) begin
            step();
            n++;
        end
        check("t4_pre_words", 32'(sent[2]), 32'd2);
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("full_no_wr", 32'(snap_wr), 32'd0);
            check("full_hold_gnt", 32'(snap_gnt), 32'h4);
        end
        fifo_full = 1'b0;
        step();
        check("full_resume", 32'(snap_wr), 32'd1);
        run_done(100);
        check("t4_wr_cnt", 32'(wr_cnt), 32'd5);

        // Owner withdraws early: one bubble, then 3 beats 0.
        do_reset();
        load(2, 1, 8'h60);
        load(3, 1, 8'h70);
        push_burst(2, 8'h60, 1);
        push_burst(3, 8'h70, 1);
        push_burst(0, 8'h80, 1);
        drive();
        step();
        load(0, 1, 8'h80);
        drive();
        step();
        check("t5_first_gnt", 32'(snap_gnt), 32'h4);
        step();
        check("t5_bubble", 32'(snap_wr), 32'd0);
        step();
        check("t5_next_gnt", 32'(snap_gnt), 32'h8);
        check("t5_next_owner", 32'(snap_owner), 32'd3);
        run_done(100);
        check("t5_wr_cnt", 32'(wr_cnt), 32'd3);

        // Asynchronous reset mid-burst.
        do_reset();
        load(1, 8, 8'h90);
        push_burst(1, 8'h90, 8);
        drive();
        n = 0;
        while (sent[1] != 8'd2 && n < 50) begin
            step();
            n++;
        end
        check("t6_pre_words", 32'(sent[1]), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_wr", 32'(fifo_wr), 32'd0);
        rst = 1'b0;
        rem[1] = 0;
        sb.delete();
        load(3, 1, 8'hE0);
        push_burst(3, 8'hE0, 1);
        drive();
        step();
        step();
        check("t6_regrant", 32'(snap_gnt), 32'h8);
        run_done(100);
        check("t6_wr_cnt", 32'(wr_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
